// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single-outstanding memory port.
// Alternates ownership under contention and aborts stuck transactions after TIMEOUT wait cycles.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            owner, owner_nxt;
  logic            last_owner, last_owner_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            mem_req_nxt, mem_we_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [DW-1:0]   mem_wdata_nxt;
  logic [SW-1:0]   mem_wstrb_nxt;
  logic [DW-1:0]   if_rdata_nxt, d_rdata_nxt;
  logic            if_ready_nxt, d_ready_nxt;
  logic            err_nxt;

  logic            d_req;
  logic [CW-1:0]   cnt_inc;
  logic            limit_hit;

  assign d_req     = d_read | d_write;
  assign cnt_inc   = cnt + CW'(1);
  assign limit_hit = (cnt_inc == CW'(TIMEOUT));

  // Completion is visible to each pipeline stage only in RESP for its own transaction
  assign stall_if  = if_req & ~((state == RESP) & (owner == OWN_IF));
  assign stall_mem = d_req  & ~((state == RESP) & (owner == OWN_D));

  // Next-state and register-update logic
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    mem_wstrb_nxt  = mem_wstrb;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
    if_ready_nxt   = 1'b0;
    d_ready_nxt    = 1'b0;
    err_nxt        = err;
    mem_req_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        // Data side wins unless it just had the bus and fetch is waiting
        if (d_req && !(last_owner == OWN_D && if_req)) begin
          state_nxt      = D_WAIT;
          owner_nxt      = OWN_D;
          last_owner_nxt = OWN_D;
          cnt_nxt        = '0;
          mem_we_nxt     = d_write;
          mem_addr_nxt   = d_addr;
          mem_wdata_nxt  = d_wdata;
          mem_wstrb_nxt  = d_write ? d_wstrb : '0;
        end else if (if_req) begin
          state_nxt      = IF_WAIT;
          owner_nxt      = OWN_IF;
          last_owner_nxt = OWN_IF;
          cnt_nxt        = '0;
          mem_we_nxt     = 1'b0;
          mem_addr_nxt   = if_addr;
          mem_wdata_nxt  = '0;
          mem_wstrb_nxt  = '0;
        end
      end
      IF_WAIT, D_WAIT: begin
        if (mem_ack || limit_hit) begin
          state_nxt = RESP;
          if (owner == OWN_D) begin
            d_rdata_nxt = mem_ack ? mem_rdata : '0;
            d_ready_nxt = 1'b1;
          end else begin
            if_rdata_nxt = mem_ack ? mem_rdata : '0;
            if_ready_nxt = 1'b1;
          end
          if (!mem_ack) err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    mem_req_nxt = (state_nxt == IF_WAIT) || (state_nxt == D_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_wstrb  <= mem_wstrb_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      if_ready   <= if_ready_nxt;
      d_ready    <= d_ready_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions,
// a negedge monitor pops and checks them whenever a ready pulse appears.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if, stall_mem, err;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic void push(input logic is_d, input logic [31:0] data, input logic e);
    exp_t x;
    x.is_d = is_d;
    x.data = data;
    x.err  = e;
    exp_q.push_back(x);
  endfunction

  // Monitor: every ready pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (rst && (if_ready || d_ready)) begin
      exp_t e;
      chk("both_ready", 32'(if_ready & d_ready), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("ready_owner", 32'(d_ready), 32'(e.is_d));
        chk("rdata", d_ready ? d_rdata : if_rdata, e.data);
        chk("err_at_ready", 32'(err), 32'(e.err));
      end
    end
  end

  // One transaction; ack_cyc = WAIT cycle carrying mem_ack (0 = never acked)
  task automatic do_txn(input logic is_d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int ack_cyc, input logic [31:0] rdata,
                        input logic drop_early, input logic exp_err);
    int n;
    push(is_d, (ack_cyc == 0) ? 32'd0 : rdata, exp_err);
    if (is_d) begin
      d_read = ~wr; d_write = wr; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    chk("grant_seen", 32'(mem_req), 32'd1);
    chk("mem_we", 32'(mem_we), 32'(is_d & wr));
    chk("mem_addr", mem_addr, addr);
    chk("mem_wdata", mem_wdata, is_d ? wdata : 32'd0);
    chk("mem_wstrb", 32'(mem_wstrb), (is_d && wr) ? 32'(wstrb) : 32'd0);
    chk("stall_wait", 32'(is_d ? stall_mem : stall_if), 32'd1);
    if (drop_early) begin
      if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
    if (ack_cyc > 0) begin
      repeat (ack_cyc - 1) @(negedge clk);
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_held", mem_addr, addr);
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_ack = 1'b0;
    end else begin
      n = 1;
      @(negedge clk);
      while (mem_req && n < 300) begin
        n++;
        @(negedge clk);
      end
      chk("timeout_len", 32'(n), 32'(TO));
    end
    chk("req_low_resp", 32'(mem_req), 32'd0);
    if (!drop_early) chk("stall_resp", 32'(is_d ? stall_mem : stall_if), 32'd0);
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", 32'(if_ready | d_ready), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_ready", 32'(if_ready | d_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Contention held from reset: D, IF, D, IF
    if_req = 1'b1; if_addr = 32'h0040_0100; d_read = 1'b1; d_addr = 32'h1001_0100;
    for (int i = 0; i < 4; i++)
      push(i % 2 == 0, (i % 2 == 0) ? 32'hD000_0000 + 32'(i) : 32'h1F00_0000 + 32'(i), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!mem_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("cont_grant", 32'(mem_req), 32'd1);
      chk("cont_addr", mem_addr, (i % 2 == 0) ? 32'h1001_0100 : 32'h0040_0100);
      mem_ack = 1'b1;
      mem_rdata = (i % 2 == 0) ? 32'hD000_0000 + 32'(i) : 32'h1F00_0000 + 32'(i);
      @(negedge clk);
      mem_ack = 1'b0;
      if (i == 3) begin
        if_req = 1'b0; d_read = 1'b0;
      end
    end
    @(negedge clk);

    do_txn(1'b0, 1'b0, 32'h0040_0000, 32'd0, 4'h0, 1, 32'h8C01_0004, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("if_rdata_hold", if_rdata, 32'h8C01_0004);
    do_txn(1'b1, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, 3, 32'h0BAD_F00D, 1'b0, 1'b0);
    do_txn(1'b1, 1'b0, 32'h1001_0010, 32'd0, 4'h0, TO, 32'h1234_5678, 1'b0, 1'b0);
    chk("err_after_limit_ack", 32'(err), 32'd0);
    do_txn(1'b0, 1'b0, 32'h0040_0010, 32'd0, 4'h0, 2, 32'hCAFE_0001, 1'b1, 1'b0);
    do_txn(1'b1, 1'b0, 32'h1001_0020, 32'd0, 4'h0, 0, 32'd0, 1'b0, 1'b1);
    do_txn(1'b0, 1'b0, 32'h0040_0020, 32'd0, 4'h0, 1, 32'h1111_2222, 1'b0, 1'b1);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset during D_WAIT, stray ack right after release
    d_read = 1'b1; d_addr = 32'h1001_0030;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    chk("rstw_grant", 32'(mem_req), 32'd1);
    rst = 1'b0; d_read = 1'b0;
    #1;
    chk("rstw_req_async", 32'(mem_req), 32'd0);
    chk("rstw_err_clr", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstw_req_idle", 32'(mem_req), 32'd0);
      chk("rstw_no_ready", 32'(d_ready), 32'd0);
      @(negedge clk);
    end
    chk("rstw_d_rdata", d_rdata, 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, wait cycles (1..255) in a WAIT state before abort.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch data, valid with if_ready.
- if_ready  out  1  one-cycle fetch completion pulse.
- d_read / d_write  in  1 / 1  data load / store request, held until d_ready (never both).
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  byte enables.
- d_rdata  out  32  load data, valid with d_ready.
- d_ready  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched write data.
- mem_wstrb  out  4  latched strobes; 4'b0000 on reads.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- stall_if  out  1  IF stage hold.
- stall_mem  out  1  MEM stage hold.
- err  out  1  sticky timeout flag.

Function
REQ-003 SHALL implement states IDLE, IF_WAIT, D_WAIT, RESP with a registered owner bit (IF/D) and last_owner bit.
REQ-004 In IDLE, grant SHALL be: D if (d_read|d_write) and not (last_owner==D and if_req); else IF if if_req; else stay IDLE.
REQ-005 On grant, the edge SHALL latch address, wdata, wstrb, and we (=d_write for D, 0 for IF) into mem_* registers, set owner and last_owner, and enter D_WAIT/IF_WAIT.
REQ-006 mem_req SHALL be 1 exactly while in IF_WAIT or D_WAIT.
REQ-007 In a WAIT state, mem_ack=1 SHALL capture mem_rdata into the owner's rdata register and enter RESP.
REQ-008 RESP SHALL last exactly one cycle, assert the owner's ready, then return to IDLE; no grant is evaluated in RESP.
REQ-009 Minimum latency: request seen in IDLE at cycle N, mem_ack at N+1 -> ready at N+2; a new grant can occur no earlier than N+3.
REQ-010 An 8-bit wait counter SHALL clear on grant and increment each WAIT cycle without mem_ack; reaching TIMEOUT without mem_ack SHALL zero the owner's rdata, set err, and enter RESP.
REQ-011 mem_ack in IDLE or RESP SHALL be ignored.
REQ-012 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as a normal completion; err is unchanged.
REQ-013 err, once set, SHALL remain 1 until reset.
REQ-014 stall_if = if_req and not (RESP and owner==IF); stall_mem = (d_read|d_write) and not (RESP and owner==D); both combinational.
REQ-015 if_rdata/d_rdata SHALL hold their last captured value between completions.
REQ-016 A request dropped mid-WAIT SHALL not abort the memory transaction; it completes and ready still pulses.

Reset
REQ-017 On rst low, asynchronously: state=IDLE, owner=IF, last_owner=IF, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0, err=0.
REQ-018 Reset asserted mid-transaction SHALL discard it; any mem_ack after release while in IDLE is ignored.

Verification
REQ-019 Lone fetch: if_req=1, if_addr=0x00400000, mem_ack 1 cycle after mem_req with mem_rdata=0x8C010004 -> mem_we=0, if_ready pulse 1 cycle, if_rdata=0x8C010004, stall_if low only in that cycle.
REQ-020 Store: d_write=1, d_addr=0x10010008, d_wdata=0xDEADBEEF, d_wstrb=4'b1111 -> mem_we=1, mem_addr=0x10010008, mem_wdata=0xDEADBEEF, mem_wstrb=4'b1111 held until mem_ack, then d_ready pulse.
REQ-021 Contention: if_req and d_read both held from reset -> grants D, IF, D, IF ...; neither ready ever appears twice in a row while both request.
REQ-022 Timeout: TIMEOUT=4, d_read with mem_ack never asserted -> mem_req high 4 cycles, then d_ready pulse, d_rdata=0, err=1 stays high through later successful transactions.
REQ-023 Reset mid-WAIT: rst low during D_WAIT, mem_ack pulsed right after release -> mem_req=0, no d_ready pulse, state IDLE.
REQ-024 Ack-at-limit: TIMEOUT=3, mem_ack on the cycle the counter reaches 3 with mem_rdata=0x12345678 -> d_rdata=0x12345678, err=0.
